// File: rtl/xor_unit_arbiter.sv
// Round-robin arbiter sharing one XOR unit between two requesters; response at T+3+k, timeout at T+2+TMO.
// Requests are accepted only in IDLE; responses are single-cycle pulses with no backpressure.
module xor_unit_arbiter #(
  parameter int W   = 1,
  parameter int TMO = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic         req1_valid,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         req0_ready,
  output logic         req1_ready,
  output logic         rsp0_valid,
  output logic         rsp1_valid,
  output logic [W-1:0] rsp_d,
  output logic         rsp_err,
  output logic [W-1:0] unit_a,
  output logic [W-1:0] unit_b,
  output logic         unit_start,
  input  logic         unit_done,
  input  logic [W-1:0] unit_d,
  output logic         spurious
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } op_t;

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         last_grant_q, last_grant_d;
  logic         owner_q, owner_d;
  logic         spurious_q, spurious_d;
  logic         err_q, err_d;
  logic [W-1:0] d_q, d_d;
  op_t          op_q, op_d;
  logic         any_req;
  logic         gnt;

  // With both pending, the requester not served last wins; a lone requester always wins.
  always_comb begin
    any_req = req0_valid | req1_valid;
    gnt     = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      spurious_q   <= 1'b0;
      err_q        <= 1'b0;
      d_q          <= '0;
      op_q         <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      spurious_q   <= spurious_d;
      err_q        <= err_d;
      d_q          <= d_d;
      op_q         <= op_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    err_d        = err_q;
    d_d          = d_q;
    op_d         = op_q;
    spurious_d   = spurious_q | (unit_done && (state_q != WAIT));
    case (state_q)
      IDLE: begin
        if (any_req) begin
          op_d.a       = gnt ? req1_a : req0_a;
          op_d.b       = gnt ? req1_b : req0_b;
          owner_d      = gnt;
          last_grant_d = gnt;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A done arriving on the last allowed cycle still counts as success.
        if (unit_done) begin
          d_d     = unit_d;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == 4'(TMO - 1)) begin
          d_d     = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    rsp_d      = '0;
    rsp_err    = 1'b0;
    unit_a     = '0;
    unit_b     = '0;
    unit_start = 1'b0;
    spurious   = 1'b0;
    if (!rst) begin
      spurious = spurious_q;
      case (state_q)
        IDLE: begin
          req0_ready = any_req & ~gnt;
          req1_ready = any_req & gnt;
        end
        ISSUE: begin
          unit_start = 1'b1;
          unit_a     = op_q.a;
          unit_b     = op_q.b;
        end
        WAIT: begin
          unit_a = op_q.a;
          unit_b = op_q.b;
        end
        RESP: begin
          unit_a     = op_q.a;
          unit_b     = op_q.b;
          rsp0_valid = ~owner_q;
          rsp1_valid = owner_q;
          rsp_d      = d_q;
          rsp_err    = err_q;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xor_unit_arbiter.sv
// Directed bench for xor_unit_arbiter: arbitration order, latency, timeout, spurious flag, reset.
module tb_xor_unit_arbiter;
  localparam int W   = 4;
  localparam int TMO = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [W-1:0] rsp_d, unit_a, unit_b;
  logic         rsp_err, unit_start, spurious;
  logic         unit_done = 1'b0;
  logic [W-1:0] unit_d = '0;

  int n_checks = 0;
  int n_err    = 0;

  xor_unit_arbiter #(.W(W), .TMO(TMO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_d(rsp_d), .rsp_err(rsp_err),
    .unit_a(unit_a), .unit_b(unit_b), .unit_start(unit_start),
    .unit_done(unit_done), .unit_d(unit_d), .spurious(spurious)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_zero"}, {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_d, rsp_err,
                         unit_a, unit_b, unit_start, spurious}, 32'h0);
  endtask

  // Caller sets the request valids/operands in the IDLE cycle. k = WAIT cycles before done;
  // k >= TMO means done never comes and a timeout response is expected.
  task automatic txn(input string tag, input int g, input logic [W-1:0] ea, input logic [W-1:0] eb,
                     input int k, input logic [W-1:0] ud);
    int nw;
    #1;
    chk({tag, "_rdy0"}, req0_ready, (g == 0));
    chk({tag, "_rdy1"}, req1_ready, (g == 1));
    cyc();
    chk({tag, "_start"}, unit_start, 1);
    chk({tag, "_ops"}, {unit_a, unit_b}, {ea, eb});
    chk({tag, "_rdy_issue"}, {req0_ready, req1_ready}, 0);
    cyc();
    nw = (k < TMO) ? k + 1 : TMO;
    for (int i = 0; i < nw; i++) begin
      unit_done = (i == k);
      unit_d    = ud;
      #1;
      chk({tag, "_wait_rsp"}, {rsp0_valid, rsp1_valid, unit_start}, 0);
      chk({tag, "_wait_ops"}, {unit_a, unit_b}, {ea, eb});
      cyc();
      unit_done = 1'b0;
    end
    #1;
    chk({tag, "_rsp_vld"}, {rsp0_valid, rsp1_valid}, (g == 0) ? 2'b10 : 2'b01);
    chk({tag, "_rsp_d"}, rsp_d, (k < TMO) ? ud : '0);
    chk({tag, "_rsp_err"}, rsp_err, (k >= TMO));
    chk({tag, "_rsp_ops"}, {unit_a, unit_b}, {ea, eb});
    cyc();
  endtask

  initial begin
    // Reset state: outputs forced low even with a request and a done present.
    req0_valid = 1'b1;
    unit_done  = 1'b1;
    #2;
    chk_all_zero("reset");
    cyc();
    chk_all_zero("reset_hold");
    unit_done  = 1'b0;
    req0_valid = 1'b0;
    rst        = 1'b0;
    #1;
    chk_all_zero("after_reset");
    cyc();

    // Both valid continuously: grants 0,1,0,1.
    req0_valid = 1'b1; req0_a = 4'h3; req0_b = 4'h5;
    req1_valid = 1'b1; req1_a = 4'h9; req1_b = 4'h6;
    txn("rr0", 0, 4'h3, 4'h5, 0, 4'h6);
    txn("rr1", 1, 4'h9, 4'h6, 2, 4'hF);
    txn("rr2", 0, 4'h3, 4'h5, 1, 4'h6);
    txn("rr3", 1, 4'h9, 4'h6, 0, 4'hF);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk("rr_idle_rdy", {req0_ready, req1_ready}, 0);
    cyc();

    // Lone req0 a=1 b=1, done after one WAIT cycle with unit_d=0.
    req0_valid = 1'b1; req0_a = 4'h1; req0_b = 4'h1;
    txn("lat", 0, 4'h1, 4'h1, 1, 4'h0);
    req0_valid = 1'b0;
    #1;
    chk("lat_idle_ops", {unit_a, unit_b, rsp0_valid}, 0);
    cyc();

    // Timeout on req1 (last grant was 0, but a lone requester still wins), then next accepted at T+7.
    req1_valid = 1'b1; req1_a = 4'h4; req1_b = 4'h2;
    txn("tmo", 1, 4'h4, 4'h2, TMO, 4'h0);
    req1_valid = 1'b0;
    // Done arrives exactly when the counter reaches TMO-1: done wins.
    req0_valid = 1'b1; req0_a = 4'h7; req0_b = 4'hD;
    txn("edge", 0, 4'h7, 4'hD, TMO - 1, 4'hA);
    req0_valid = 1'b0;
    #1;
    chk("spur_before", spurious, 0);
    cyc();

    // Spurious done in IDLE.
    unit_done = 1'b1; unit_d = 4'h5;
    #1;
    chk("spur_rsp", {rsp0_valid, rsp1_valid}, 0);
    cyc();
    unit_done = 1'b0;
    #1;
    chk("spur_set", spurious, 1);
    chk("spur_norsp", {rsp0_valid, rsp1_valid}, 0);
    cyc(); cyc(); cyc();
    chk("spur_sticky", spurious, 1);

    // Reset mid-WAIT.
    req0_valid = 1'b1; req0_a = 4'hC; req0_b = 4'h3;
    cyc();
    req0_valid = 1'b0;
    cyc();
    #1;
    chk("mid_in_wait", {unit_a, unit_b}, {4'hC, 4'h3});
    rst = 1'b1;
    #1;
    chk_all_zero("mid_rst");
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("post_rst_quiet", {rsp0_valid, rsp1_valid, unit_start, spurious}, 0);
      cyc();
    end
    req1_valid = 1'b1; req1_a = 4'hB; req1_b = 4'h5;
    txn("post_req1", 1, 4'hB, 4'h5, 0, 4'hE);
    req0_valid = 1'b1; req0_a = 4'h2; req0_b = 4'h8;
    txn("post_tie", 0, 4'h2, 4'h8, 1, 4'hA);
    req0_valid = 1'b0; req1_valid = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
